skeleton: RTL and testbench



---
 rtl/skeleton_pkg.sv | 40 ++++
 rtl/skeleton_clkgen.sv | 39 +++
 rtl/skeleton_models.sv | 120 ++++++++++++
 rtl/skeleton.sv | 88 ++++++++
 tb/tb_skeleton.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/skeleton_pkg.sv
//------------------------------------------------------------------------------
// Module   : skeleton_pkg
// Brief    : Phase encoding, bus widths and opcodes shared by the skeleton slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package skeleton_pkg;

  typedef enum logic [1:0] {
    PH_PC    = 2'd0,
    PH_FETCH = 2'd1,
    PH_MEM   = 2'd2,
    PH_WB    = 2'd3
  } phase_t;

  localparam phase_t RESET_PHASE = PH_WB;

  localparam int IMEM_AW = 12;
  localparam int DMEM_AW = 12;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;

  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  // Clock levels held during a phase, packed {processor, imem, dmem, regfile}.
  function automatic logic [3:0] phase_clocks(input phase_t p);
    case (p)
      PH_PC:    phase_clocks = 4'b1001;
      PH_FETCH: phase_clocks = 4'b1100;
      PH_MEM:   phase_clocks = 4'b0110;
      default:  phase_clocks = 4'b0011;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/skeleton_clkgen.sv
//------------------------------------------------------------------------------
// Module   : skeleton_clkgen
// Brief    : Four-phase counter producing flop-driven, glitch-free phase clocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skeleton_clkgen
  import skeleton_pkg::*;
(
  input  logic clock,
  input  logic reset,
  output logic imem_clock,
  output logic dmem_clock,
  output logic processor_clock,
  output logic regfile_clock
);

  phase_t     r_phase;
  phase_t     w_next_phase;
  logic [3:0] w_next_clks;

  // Outputs are registered from the next-phase decode so they change only at clock edges.
  always_comb begin
    w_next_phase = phase_t'(r_phase + 2'd1);
    if (reset) begin
      w_next_phase = RESET_PHASE;
    end
    w_next_clks = phase_clocks(w_next_phase);
  end

  always_ff @(posedge clock) begin
    r_phase <= w_next_phase;
    {processor_clock, imem_clock, dmem_clock, regfile_clock} <= w_next_clks;
  end

endmodule

`default_nettype wire

// File: rtl/skeleton_models.sv
//------------------------------------------------------------------------------
// Module   : processor / imem / dmem / regfile
// Brief    : Minimal stand-ins for the attached cores (addi/sw/lw subset).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Resets are asynchronous: the phase clocks are parked while reset is held.
module processor
  import skeleton_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  output logic [IMEM_AW-1:0]   address_imem,
  input  logic [DATA_W-1:0]    q_imem,
  output logic [DMEM_AW-1:0]   address_dmem,
  output logic [DATA_W-1:0]    data,
  output logic                 wren,
  input  logic [DATA_W-1:0]    q_dmem,
  output logic                 ctrl_writeEnable,
  output logic [REG_AW-1:0]    ctrl_writeReg,
  output logic [REG_AW-1:0]    ctrl_readRegA,
  output logic [REG_AW-1:0]    ctrl_readRegB,
  output logic [DATA_W-1:0]    data_writeReg,
  input  logic [DATA_W-1:0]    data_readRegA,
  input  logic [DATA_W-1:0]    data_readRegB
);

  logic [IMEM_AW-1:0] r_pc;
  logic [4:0]         w_op;
  logic [DATA_W-1:0]  w_sum;

  // All-ones reset value makes the first processor edge land on address 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pc <= '1;
    else       r_pc <= r_pc + 1'b1;
  end

  assign w_op             = q_imem[31:27];
  assign w_sum            = data_readRegA + {{15{q_imem[16]}}, q_imem[16:0]};
  assign address_imem     = r_pc;
  assign address_dmem     = w_sum[DMEM_AW-1:0];
  assign data             = data_readRegB;
  assign wren             = !reset && (w_op == OP_SW);
  assign ctrl_writeEnable = !reset && ((w_op == OP_ADDI) || (w_op == OP_LW));
  assign ctrl_writeReg    = q_imem[26:22];
  assign ctrl_readRegA    = q_imem[21:17];
  assign ctrl_readRegB    = q_imem[26:22];
  assign data_writeReg    = (w_op == OP_LW) ? q_dmem : w_sum;

endmodule

module imem
  import skeleton_pkg::*;
(
  input  logic [IMEM_AW-1:0] address,
  input  logic               clock,
  output logic [DATA_W-1:0]  q
);

  // Smoke-test program: addi $1,$0,5 ; sw $1,0($0) ; then nops.
  always_ff @(posedge clock) begin
    case (address)
      12'd0:   q <= 32'h2840_0005;
      12'd1:   q <= 32'h3840_0000;
      default: q <= 32'h0000_0000;
    endcase
  end

endmodule

module dmem
  import skeleton_pkg::*;
(
  input  logic [DMEM_AW-1:0] address,
  input  logic               clock,
  input  logic [DATA_W-1:0]  data,
  input  logic               wren,
  output logic [DATA_W-1:0]  q
);

  logic [DATA_W-1:0] r_mem [2**DMEM_AW];

  always_ff @(posedge clock) begin
    if (wren) r_mem[address] <= data;
    q <= r_mem[address];
  end

endmodule

module regfile
  import skeleton_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_writeEnable,
  input  logic              ctrl_reset,
  input  logic [REG_AW-1:0] ctrl_writeReg,
  input  logic [REG_AW-1:0] ctrl_readRegA,
  input  logic [REG_AW-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_writeReg,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB
);

  logic [DATA_W-1:0] r_regs [2**REG_AW];

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
    end else if (ctrl_writeEnable && (ctrl_writeReg != '0)) begin
      r_regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign data_readRegA = r_regs[ctrl_readRegA];
  assign data_readRegB = r_regs[ctrl_readRegB];

endmodule

`default_nettype wire

// File: rtl/skeleton.sv
//------------------------------------------------------------------------------
// Module   : skeleton
// Brief    : Single-cycle processor wrapper; phase clock generator plus wiring.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skeleton
  import skeleton_pkg::*;
(
  input  logic clock,
  input  logic reset,
  output logic imem_clock,
  output logic dmem_clock,
  output logic processor_clock,
  output logic regfile_clock
);

  logic [IMEM_AW-1:0] w_address_imem;
  logic [DATA_W-1:0]  w_q_imem;
  logic [DMEM_AW-1:0] w_address_dmem;
  logic [DATA_W-1:0]  w_data;
  logic               w_wren;
  logic [DATA_W-1:0]  w_q_dmem;
  logic               w_ctrl_write_enable;
  logic [REG_AW-1:0]  w_ctrl_write_reg;
  logic [REG_AW-1:0]  w_ctrl_read_reg_a;
  logic [REG_AW-1:0]  w_ctrl_read_reg_b;
  logic [DATA_W-1:0]  w_data_write_reg;
  logic [DATA_W-1:0]  w_data_read_reg_a;
  logic [DATA_W-1:0]  w_data_read_reg_b;

  skeleton_clkgen u_clkgen (
    .clock           (clock),
    .reset           (reset),
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .processor_clock (processor_clock),
    .regfile_clock   (regfile_clock)
  );

  processor u_processor (
    .clock            (processor_clock),
    .reset            (reset),
    .address_imem     (w_address_imem),
    .q_imem           (w_q_imem),
    .address_dmem     (w_address_dmem),
    .data             (w_data),
    .wren             (w_wren),
    .q_dmem           (w_q_dmem),
    .ctrl_writeEnable (w_ctrl_write_enable),
    .ctrl_writeReg    (w_ctrl_write_reg),
    .ctrl_readRegA    (w_ctrl_read_reg_a),
    .ctrl_readRegB    (w_ctrl_read_reg_b),
    .data_writeReg    (w_data_write_reg),
    .data_readRegA    (w_data_read_reg_a),
    .data_readRegB    (w_data_read_reg_b)
  );

  imem u_imem (
    .address (w_address_imem),
    .clock   (imem_clock),
    .q       (w_q_imem)
  );

  dmem u_dmem (
    .address (w_address_dmem),
    .clock   (dmem_clock),
    .data    (w_data),
    .wren    (w_wren),
    .q       (w_q_dmem)
  );

  regfile u_regfile (
    .clock            (regfile_clock),
    .ctrl_writeEnable (w_ctrl_write_enable),
    .ctrl_reset       (reset),
    .ctrl_writeReg    (w_ctrl_write_reg),
    .ctrl_readRegA    (w_ctrl_read_reg_a),
    .ctrl_readRegB    (w_ctrl_read_reg_b),
    .data_writeReg    (w_data_write_reg),
    .data_readRegA    (w_data_read_reg_a),
    .data_readRegB    (w_data_read_reg_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_skeleton.sv
//------------------------------------------------------------------------------
// Module   : tb_skeleton
// Brief    : Self-checking bench for the skeleton phase clocks and wiring.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_skeleton;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic imem_clock, dmem_clock, processor_clock, regfile_clock;

  int checks = 0;
  int errors = 0;
  int ph     = 3;

  skeleton dut (
    .clock           (clock),
    .reset           (reset),
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .processor_clock (processor_clock),
    .regfile_clock   (regfile_clock)
  );

  always #10 clock = ~clock;

  // Expected levels {processor, imem, dmem, regfile} after an edge into phase p.
  function automatic logic [3:0] pattern(input int p);
    case (p)
      0:       pattern = 4'b1001;
      1:       pattern = 4'b1100;
      2:       pattern = 4'b0110;
      default: pattern = 4'b0011;
    endcase
  endfunction

  // Entering phase p, exactly one clock rises: processor, imem, dmem, regfile in turn.
  function automatic logic [3:0] riser(input int p);
    riser = 4'b1000 >> p;
  endfunction

  function automatic logic [3:0] obs();
    obs = {processor_clock, imem_clock, dmem_clock, regfile_clock};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) ph = 3;
    else       ph = (ph + 1) % 4;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] snap;
    #1 reset = 1'b1;
    tick();
    checks++;
    if (obs() !== 4'b0011) begin
      errors++; $display("FAIL reset_first_edge: got %b want 0011", obs());
    end
    checks++;
    if (dut.u_regfile.r_regs[1] !== 32'd0) begin
      errors++; $display("FAIL reset_r1_clear: got %0d want 0", dut.u_regfile.r_regs[1]);
    end
    snap = dut.u_dmem.r_mem[0];
    tick();
    checks++;
    if (obs() !== 4'b0011 || $time != 31) begin
      errors++; $display("FAIL reset_hold: got %b at %0t want 0011 at 31", obs(), $time);
    end
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (dut.u_dmem.r_mem[0] !== snap) begin
      errors++; $display("FAIL reset_no_store: got %h want %h", dut.u_dmem.r_mem[0], snap);
    end
  endtask

  task automatic test_reset_exit();
    logic [3:0] prev, cur;
    prev = obs();
    for (int i = 0; i < 5; i++) begin
      tick();
      cur = obs();
      checks++;
      if (cur !== pattern(ph) || (cur & ~prev) !== riser(ph) || $time != 51 + 20 * i) begin
        errors++;
        $display("FAIL exit_seq%0d: got %b rise %b at %0t want %b rise %b at %0d",
                 i, cur, cur & ~prev, $time, pattern(ph), riser(ph), 51 + 20 * i);
      end
      prev = cur;
    end
  endtask

  task automatic test_program();
    repeat (4) tick();
    checks++;
    if (dut.u_regfile.r_regs[1] !== 32'd5) begin
      errors++; $display("FAIL prog_r1: got %0d want 5", dut.u_regfile.r_regs[1]);
    end
    checks++;
    if (dut.u_dmem.r_mem[0] !== 32'd5) begin
      errors++; $display("FAIL prog_dmem0: got %0d want 5", dut.u_dmem.r_mem[0]);
    end
  endtask

  task automatic test_period();
    longint r1t[4], r2t[4], ft[4];
    int nr[4];
    logic [3:0] prev, cur;
    for (int k = 0; k < 4; k++) begin
      nr[k] = 0; r1t[k] = 0; r2t[k] = 0; ft[k] = -1;
    end
    prev = obs();
    repeat (12) begin
      tick();
      cur = obs();
      for (int k = 0; k < 4; k++) begin
        if (cur[3-k] && !prev[3-k]) begin
          if (nr[k] == 0) r1t[k] = $time;
          else if (nr[k] == 1) r2t[k] = $time;
          nr[k]++;
        end
        if (!cur[3-k] && prev[3-k] && nr[k] == 1) ft[k] = $time;
      end
      prev = cur;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (nr[k] < 2 || r2t[k] - r1t[k] != 80 || ft[k] - r1t[k] != 40) begin
        errors++;
        $display("FAIL period_clk%0d: rises %0d period %0d high %0d want period 80 high 40",
                 k, nr[k], r2t[k] - r1t[k], ft[k] - r1t[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] prev;
    int guard = 0;
    while (ph != 1 && guard < 8) begin
      tick();
      guard++;
    end
    checks++;
    if (ph != 1) begin
      errors++; $display("FAIL mid_sync: got phase %0d want 1", ph);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    checks++;
    if (obs() !== 4'b0011) begin
      errors++; $display("FAIL mid_reset_pattern: got %b want 0011", obs());
    end
    @(negedge clock);
    checks++;
    if (dut.u_regfile.r_regs[1] !== 32'd0) begin
      errors++; $display("FAIL mid_reset_r1: got %0d want 0", dut.u_regfile.r_regs[1]);
    end
    reset = 1'b0;
    prev = obs();
    tick();
    checks++;
    if (obs() !== 4'b1001 || (obs() & ~prev) !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_exit: got %b rise %b want 1001 rise 1000", obs(), obs() & ~prev);
    end
    repeat (7) tick();
    checks++;
    if (dut.u_regfile.r_regs[1] !== 32'd5) begin
      errors++; $display("FAIL mid_rerun_r1: got %0d want 5", dut.u_regfile.r_regs[1]);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev, cur;
    prev = obs();
    for (int n = 0; n < 5000; n++) begin
      @(negedge clock);
      checks++;
      if (obs() !== prev) begin
        errors++; $display("FAIL rand_midcycle%0d: got %b want %b", n, obs(), prev);
      end
      reset = ($urandom_range(0, 99) < 3);
      tick();
      cur = obs();
      checks++;
      if (cur !== pattern(ph)) begin
        errors++; $display("FAIL rand_level%0d: got %b want %b", n, cur, pattern(ph));
      end
      if (!reset) begin
        checks++;
        if ((cur & ~prev) !== riser(ph)) begin
          errors++; $display("FAIL rand_rise%0d: got %b want %b", n, cur & ~prev, riser(ph));
        end
      end
      prev = cur;
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_exit();
    test_program();
    test_period();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
